// File: rtl/noc_router_pkg.sv
// Shared router types: allocator state encoding and port index constants.
package noc_router_pkg;

    typedef enum logic {
        ALLOC_IDLE   = 1'b0,
        ALLOC_LOCKED = 1'b1
    } alloc_state_t;

    localparam int unsigned LOCAL = 0;
    localparam int unsigned NORTH = 1;
    localparam int unsigned SOUTH = 2;
    localparam int unsigned EAST  = 3;
    localparam int unsigned WEST  = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping to 0.
module rr_arbiter #(
    parameter int unsigned N  = 5,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx,
    output logic          any
);

    int unsigned v_pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        v_pos = 0;
        for (int unsigned i = 0; i < N; i++) begin
            v_pos = 32'(ptr) + i;
            if (v_pos >= N) begin
                v_pos = v_pos - N;
            end
            if (!any && req[IW'(v_pos)]) begin
                any               = 1'b1;
                idx               = IW'(v_pos);
                grant[IW'(v_pos)] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/output_port_allocator.sv
// Per-output switch allocator: round-robin head arbitration, wormhole lock until tail,
// and downstream credit tracking. Grant/send are combinational from the current state.
module output_port_allocator
    import noc_router_pkg::*;
#(
    parameter int unsigned NUM_INPUTS        = 5,
    parameter int unsigned FLIT_BUFFER_DEPTH = 2,
    parameter int unsigned CREDIT_WIDTH      = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_INPUTS-1:0]         req,
    input  logic [NUM_INPUTS-1:0]         is_tail,
    input  logic [NUM_INPUTS-1:0]         disable_in,
    input  logic                          credit_in,
    output logic [NUM_INPUTS-1:0]         grant,
    output logic                          send_out,
    output logic                          is_tail_out,
    output logic                          locked,
    output logic [$clog2(NUM_INPUTS)-1:0] owner,
    output logic [CREDIT_WIDTH-1:0]       credits,
    output logic                          credit_error
);

    localparam int unsigned OW = $clog2(NUM_INPUTS);
    localparam logic [CREDIT_WIDTH-1:0] MAX_CREDITS = CREDIT_WIDTH'(FLIT_BUFFER_DEPTH);
    localparam logic [OW-1:0]           LAST_IDX    = OW'(NUM_INPUTS - 1);

    alloc_state_t              r_state;
    alloc_state_t              w_next_state;
    logic [OW-1:0]             r_rr_ptr;
    logic [OW-1:0]             w_next_rr_ptr;
    logic [OW-1:0]             r_owner;
    logic [OW-1:0]             w_next_owner;
    logic [CREDIT_WIDTH-1:0]   r_credits;
    logic                      r_credit_error;

    logic [NUM_INPUTS-1:0]     w_elig;
    logic [NUM_INPUTS-1:0]     w_arb_grant;
    logic [OW-1:0]             w_arb_idx;
    logic                      w_arb_any;
    logic                      w_has_credit;

    assign w_elig       = req & ~disable_in;
    assign w_has_credit = (r_credits != '0);

    rr_arbiter #(
        .N  (NUM_INPUTS),
        .IW (OW)
    ) u_rr_arbiter (
        .req   (w_elig),
        .ptr   (r_rr_ptr),
        .grant (w_arb_grant),
        .idx   (w_arb_idx),
        .any   (w_arb_any)
    );

    // Next-state and per-cycle grant/send decode.
    always_comb begin
        w_next_state  = r_state;
        w_next_rr_ptr = r_rr_ptr;
        w_next_owner  = r_owner;
        grant         = '0;
        send_out      = 1'b0;
        is_tail_out   = 1'b0;
        case (r_state)
            ALLOC_IDLE: begin
                if (w_arb_any && w_has_credit) begin
                    grant        = w_arb_grant;
                    send_out     = 1'b1;
                    is_tail_out  = is_tail[w_arb_idx];
                    w_next_owner = w_arb_idx;
                    if (is_tail[w_arb_idx]) begin
                        w_next_rr_ptr = (w_arb_idx == LAST_IDX) ? '0 : w_arb_idx + 1'b1;
                    end else begin
                        w_next_state = ALLOC_LOCKED;
                    end
                end
            end
            ALLOC_LOCKED: begin
                // Bubbles from the owner hold the lock; nobody else is considered.
                if (req[r_owner] && w_has_credit) begin
                    grant          = '0;
                    grant[r_owner] = 1'b1;
                    send_out       = 1'b1;
                    is_tail_out    = is_tail[r_owner];
                    if (is_tail[r_owner]) begin
                        w_next_state  = ALLOC_IDLE;
                        w_next_rr_ptr = (r_owner == LAST_IDX) ? '0 : r_owner + 1'b1;
                    end
                end
            end
            default: w_next_state = ALLOC_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ALLOC_IDLE;
            r_rr_ptr       <= '0;
            r_owner        <= '0;
            r_credits      <= MAX_CREDITS;
            r_credit_error <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_rr_ptr <= w_next_rr_ptr;
            r_owner  <= w_next_owner;
            // Send and returned credit in the same cycle cancel out.
            case ({send_out, credit_in})
                2'b10: r_credits <= r_credits - 1'b1;
                2'b01: begin
                    if (r_credits == MAX_CREDITS) begin
                        r_credit_error <= 1'b1;
                    end else begin
                        r_credits <= r_credits + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign locked       = (r_state == ALLOC_LOCKED);
    assign owner        = r_owner;
    assign credits      = r_credits;
    assign credit_error = r_credit_error;

endmodule

// File: tb/tb_output_port_allocator.sv
// Scoreboard bench for output_port_allocator: expected sends are queued by the stimulus
// and consumed by a negedge monitor; state outputs are checked directly.
module tb_output_port_allocator;

    localparam logic [4:0] TL = 5'b11111;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] req;
    logic [4:0] is_tail;
    logic [4:0] disable_in;
    logic       credit_in;
    logic [4:0] grant;
    logic       send_out;
    logic       is_tail_out;
    logic       locked;
    logic [2:0] owner;
    logic [1:0] credits;
    logic       credit_error;

    typedef struct packed {
        logic [4:0] g;
        logic       t;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_errors = 0;

    output_port_allocator #(
        .NUM_INPUTS        (5),
        .FLIT_BUFFER_DEPTH (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .is_tail      (is_tail),
        .disable_in   (disable_in),
        .credit_in    (credit_in),
        .grant        (grant),
        .send_out     (send_out),
        .is_tail_out  (is_tail_out),
        .locked       (locked),
        .owner        (owner),
        .credits      (credits),
        .credit_error (credit_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drv(input logic [4:0] r, input logic [4:0] t, input logic [4:0] d,
                       input logic c);
        req        = r;
        is_tail    = t;
        disable_in = d;
        credit_in  = c;
        #1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] g, input logic t);
        exp_t x;
        x.g = g;
        x.t = t;
        q.push_back(x);
    endtask

    // Monitor: every send must match the next queued expectation.
    always @(negedge clk) begin
        if (send_out) begin
            if (q.size() == 0) begin
                chk("unexpected_send", 32'(grant), 0);
            end else begin
                e = q.pop_front();
                chk("send_grant", 32'(grant), 32'(e.g));
                chk("send_tail", 32'(is_tail_out), 32'(e.t));
            end
        end else begin
            chk("idle_grant", 32'(grant), 0);
        end
    end

    initial begin
        rst = 1'b1;
        drv(5'b0, 5'b0, 5'b0, 1'b0);
        cyc();
        cyc();
        rst = 1'b0;
        chk("rst_credits", 32'(credits), 2);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_err", 32'(credit_error), 0);
        chk("rst_owner", 32'(owner), 0);
        chk("rst_send", 32'(send_out), 0);

        // Single-flit packet from input 2, same-cycle grant.
        drv(5'b00100, TL, 5'b0, 1'b0);
        push(5'b00100, 1'b1);
        chk("t1_send", 32'(send_out), 1);
        chk("t1_grant", 32'(grant), 32'(5'b00100));
        cyc();
        drv(5'b0, 5'b0, 5'b0, 1'b0);
        chk("t1_credits", 32'(credits), 1);
        chk("t1_locked", 32'(locked), 0);
        chk("t1_owner", 32'(owner), 2);
        // rr_ptr=3 means input 4 beats input 1.
        drv(5'b10010, TL, 5'b0, 1'b1);
        push(5'b10000, 1'b1);
        cyc();
        chk("t1_rr_credits", 32'(credits), 1);

        // Two competing 3-flit streams with credit returned every cycle.
        for (int p = 0; p < 3; p++) begin
            for (int f = 0; f < 3; f++) begin
                drv(5'b10010, (f == 2) ? TL : 5'b0, 5'b0, 1'b1);
                push((p == 1) ? 5'b10000 : 5'b00010, (f == 2));
                chk("t2_locked", 32'(locked), (f > 0) ? 1 : 0);
                cyc();
            end
        end
        drv(5'b0, 5'b0, 5'b0, 1'b1);
        chk("t2_credits", 32'(credits), 1);
        chk("t2_owner", 32'(owner), 1);
        chk("t2_locked_end", 32'(locked), 0);
        cyc();
        chk("t2_refill", 32'(credits), 2);

        // Lock on input 2, run out of credits, input 0 must never win.
        drv(5'b00100, 5'b0, 5'b0, 1'b0);
        push(5'b00100, 1'b0);
        cyc();
        chk("t3_locked", 32'(locked), 1);
        chk("t3_credits1", 32'(credits), 1);
        drv(5'b00101, 5'b0, 5'b0, 1'b0);
        push(5'b00100, 1'b0);
        cyc();
        chk("t3_credits0", 32'(credits), 0);
        drv(5'b00101, 5'b0, 5'b0, 1'b0);
        chk("t3_stall_send", 32'(send_out), 0);
        chk("t3_stall_grant", 32'(grant), 0);
        cyc();
        drv(5'b00101, 5'b0, 5'b0, 1'b1);
        chk("t3_stall_send2", 32'(send_out), 0);
        cyc();
        drv(5'b00101, TL, 5'b0, 1'b0);
        push(5'b00100, 1'b1);
        chk("t3_resume", 32'(grant), 32'(5'b00100));
        cyc();
        drv(5'b00001, TL, 5'b0, 1'b0);
        chk("t3_nocredit_idle", 32'(send_out), 0);
        chk("t3_unlocked", 32'(locked), 0);
        cyc();
        drv(5'b0, 5'b0, 5'b0, 1'b1);
        cyc();
        cyc();
        chk("t3_refill", 32'(credits), 2);
        chk("t3_err", 32'(credit_error), 0);

        // Turn disable: input 0 masked; disabling input 1 mid-packet is ignored.
        drv(5'b00011, 5'b0, 5'b00001, 1'b1);
        push(5'b00010, 1'b0);
        cyc();
        drv(5'b00011, 5'b0, 5'b00011, 1'b1);
        push(5'b00010, 1'b0);
        chk("t4_locked", 32'(locked), 1);
        cyc();
        drv(5'b00011, TL, 5'b00011, 1'b1);
        push(5'b00010, 1'b1);
        cyc();
        drv(5'b0, 5'b0, 5'b0, 1'b0);
        chk("t4_unlocked", 32'(locked), 0);
        chk("t4_owner", 32'(owner), 1);
        chk("t4_credits", 32'(credits), 2);
        chk("t4_err", 32'(credit_error), 0);

        // Credit overflow is saturated and sticky.
        drv(5'b0, 5'b0, 5'b0, 1'b1);
        cyc();
        chk("t5_sat", 32'(credits), 2);
        chk("t5_err", 32'(credit_error), 1);
        drv(5'b0, 5'b0, 5'b0, 1'b0);
        cyc();
        chk("t5_err_sticky", 32'(credit_error), 1);
        drv(5'b00001, TL, 5'b0, 1'b0);
        push(5'b00001, 1'b1);
        cyc();
        chk("t5_credits1", 32'(credits), 1);
        drv(5'b00001, TL, 5'b0, 1'b1);
        push(5'b00001, 1'b1);
        cyc();
        chk("t5_send_and_credit", 32'(credits), 1);
        chk("t5_err_sticky2", 32'(credit_error), 1);

        // Reset while locked on input 3.
        drv(5'b0, 5'b0, 5'b0, 1'b1);
        cyc();
        drv(5'b01000, 5'b0, 5'b0, 1'b0);
        push(5'b01000, 1'b0);
        cyc();
        chk("t6_locked", 32'(locked), 1);
        chk("t6_owner", 32'(owner), 3);
        rst = 1'b1;
        drv(5'b0, 5'b0, 5'b0, 1'b0);
        cyc();
        rst = 1'b0;
        chk("t6_rst_locked", 32'(locked), 0);
        chk("t6_rst_credits", 32'(credits), 2);
        chk("t6_rst_err", 32'(credit_error), 0);
        chk("t6_rst_owner", 32'(owner), 0);
        // rr_ptr back at 0: input 0 wins over input 3.
        drv(5'b01001, TL, 5'b0, 1'b1);
        push(5'b00001, 1'b1);
        cyc();
        drv(5'b01000, 5'b0, 5'b0, 1'b1);
        push(5'b01000, 1'b0);
        cyc();
        chk("t6_fresh_head", 32'(locked), 1);
        drv(5'b01000, TL, 5'b0, 1'b1);
        push(5'b01000, 1'b1);
        cyc();
        drv(5'b0, 5'b0, 5'b0, 1'b0);
        chk("t6_done", 32'(locked), 0);
        cyc();
        chk("pending_sends", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
